// File: rtl/mem_arb_pkg.sv
// Shared encodings and constants for the memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Which requester owns the current access.
  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  // Legal range of the per-access wait length and the width of its counter.
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  localparam int TIMER_W  = 4;

  // Counter preload for a given wait length. Out-of-range values are clamped
  // so a bad parameter can never wrap the 4-bit counter.
  function automatic logic [TIMER_W-1:0] wait_load_value(input int wait_cycles);
    int clamped;
    clamped = wait_cycles;
    if (clamped < WAIT_MIN) clamped = WAIT_MIN;
    if (clamped > WAIT_MAX) clamped = WAIT_MAX;
    return TIMER_W'(clamped - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the memory port arbiter.
// The arbiter uses the slave view; requesters and the RAM model use master.
interface mem_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  // fetch port
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          f_done;
  // data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  // RAM side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_read;
  logic          mem_write;
  // status
  logic          busy;

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_rdata, f_done, d_rdata, d_done,
    input  mem_addr, mem_wdata, mem_read, mem_write, busy
  );

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_rdata, f_done, d_rdata, d_done,
    output mem_addr, mem_wdata, mem_read, mem_write, busy
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Loadable 4-bit down-counter that times the RAM strobe window.
// Stops at zero; zero flag is decoded from the registered count.
module mem_wait_timer
  import mem_arb_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] count_reg;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port processor RAM between instruction fetch and
// load/store. One access at a time: IDLE -> ACCESS (WAIT strobe cycles)
// -> DONE (one-cycle done pulse to the granted port) -> IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 9,
  parameter int DW        = 32,
  parameter int WAIT      = 2,
  parameter int PRIO_DATA = 1
) (
  input logic               Clock,
  input logic               Reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [TIMER_W-1:0] WAIT_LOAD = wait_load_value(WAIT);

  state_t        state_reg;
  state_t        state_next;
  grant_t        grant_reg;
  grant_t        last_grant_reg;
  grant_t        winner;
  logic [AW-1:0] addr_reg;
  logic          we_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] f_rdata_reg;
  logic [DW-1:0] d_rdata_reg;
  logic          any_req;
  logic          grant_now;
  logic          in_access;
  logic          timer_zero;
  logic          capture;

  // Pick the winner among the current requests; only used while IDLE.
  always_comb begin
    winner  = GRANT_FETCH;
    any_req = bus.f_req | bus.d_req;
    if (bus.d_req && !bus.f_req) begin
      winner = GRANT_DATA;
    end else if (bus.d_req && bus.f_req) begin
      // Fixed data priority, or alternate away from the last owner.
      if ((PRIO_DATA != 0) || (last_grant_reg == GRANT_FETCH)) begin
        winner = GRANT_DATA;
      end else begin
        winner = GRANT_FETCH;
      end
    end
  end

  assign grant_now = (state_reg == ST_IDLE) && any_req;
  assign in_access = (state_reg == ST_ACCESS);
  // Read data is valid on the final strobe cycle, when the timer reads zero.
  assign capture   = in_access && timer_zero && !we_reg;

  mem_wait_timer u_wait_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (grant_now),
    .load_value (WAIT_LOAD),
    .dec        (in_access),
    .zero       (timer_zero)
  );

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: requests are looked at only in IDLE, DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (any_req) state_next = ST_ACCESS;
      ST_ACCESS: if (timer_zero) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Latch the winner's request at the grant edge; later input changes are ignored.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      grant_reg      <= GRANT_FETCH;
      last_grant_reg <= GRANT_FETCH;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
    end else if (grant_now) begin
      grant_reg      <= winner;
      last_grant_reg <= winner;
      if (winner == GRANT_DATA) begin
        addr_reg  <= bus.d_addr;
        we_reg    <= bus.d_we;
        wdata_reg <= bus.d_wdata;
      end else begin
        addr_reg  <= bus.f_addr;
        we_reg    <= 1'b0;
        wdata_reg <= '0;
      end
    end
  end

  // Per-port read data, updated only by that port's reads and held otherwise.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      f_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else if (capture) begin
      if (grant_reg == GRANT_DATA) begin
        d_rdata_reg <= bus.mem_rdata;
      end else begin
        f_rdata_reg <= bus.mem_rdata;
      end
    end
  end

  // Outputs decode registered state only, so no request reaches a strobe combinationally.
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_read  = in_access && !we_reg;
  assign bus.mem_write = in_access && we_reg;
  assign bus.f_done    = (state_reg == ST_DONE) && (grant_reg == GRANT_FETCH);
  assign bus.d_done    = (state_reg == ST_DONE) && (grant_reg == GRANT_DATA);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.f_rdata   = f_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (WAIT=2 data priority,
// WAIT=2 round-robin, WAIT=1 data priority) sharing one clock and reset.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_c ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(2), .PRIO_DATA(1)) u_dut_a (
    .Clock (clk), .Reset (rst_n), .bus (bus_a.slave));
  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(2), .PRIO_DATA(0)) u_dut_b (
    .Clock (clk), .Reset (rst_n), .bus (bus_b.slave));
  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(1), .PRIO_DATA(1)) u_dut_c (
    .Clock (clk), .Reset (rst_n), .bus (bus_c.slave));

  typedef struct packed {
    logic          port;   // 0 fetch, 1 data
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // RAM contents model: address 0x010 holds 0x12345678.
  function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
    logic [DW-1:0] x;
    x = {{(DW-AW){1'b0}}, a} ^ 32'h0000_0010;
    return 32'h1234_5678 ^ (x * 32'h9E37_79B1);
  endfunction

  function automatic exp_t mk_exp(input logic port, input logic [AW-1:0] addr,
                                  input logic we, input logic [DW-1:0] wdata);
    exp_t e;
    e.port  = port;
    e.addr  = addr;
    e.we    = we;
    e.wdata = wdata;
    e.rdata = model(addr);
    return e;
  endfunction

  function automatic int exp_wait(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  // RAM models: data is valid only on the last strobe cycle, garbage before.
  int rdcnt_a = 0;
  int rdcnt_b = 0;
  int rdcnt_c = 0;
  always @(posedge clk) begin
    rdcnt_a <= bus_a.mem_read ? rdcnt_a + 1 : 0;
    rdcnt_b <= bus_b.mem_read ? rdcnt_b + 1 : 0;
    rdcnt_c <= bus_c.mem_read ? rdcnt_c + 1 : 0;
  end
  always_comb bus_a.mem_rdata = (bus_a.mem_read && rdcnt_a == 1) ? model(bus_a.mem_addr)
                                                                  : (32'hBAD0_0000 | 32'(rdcnt_a));
  always_comb bus_b.mem_rdata = (bus_b.mem_read && rdcnt_b == 1) ? model(bus_b.mem_addr)
                                                                  : (32'hBAD0_0000 | 32'(rdcnt_b));
  always_comb bus_c.mem_rdata = (bus_c.mem_read && rdcnt_c == 0) ? model(bus_c.mem_addr)
                                                                  : (32'hBAD0_0000 | 32'(rdcnt_c));

  // Monitor views indexed by instance.
  logic [2:0]    m_fdone, m_ddone, m_rd, m_wr;
  logic [AW-1:0] m_addr  [3];
  logic [DW-1:0] m_wdata [3];
  logic [DW-1:0] m_frd   [3];
  logic [DW-1:0] m_drd   [3];
  assign m_fdone = {bus_c.f_done, bus_b.f_done, bus_a.f_done};
  assign m_ddone = {bus_c.d_done, bus_b.d_done, bus_a.d_done};
  assign m_rd    = {bus_c.mem_read, bus_b.mem_read, bus_a.mem_read};
  assign m_wr    = {bus_c.mem_write, bus_b.mem_write, bus_a.mem_write};
  assign m_addr[0]  = bus_a.mem_addr;   assign m_addr[1]  = bus_b.mem_addr;   assign m_addr[2]  = bus_c.mem_addr;
  assign m_wdata[0] = bus_a.mem_wdata;  assign m_wdata[1] = bus_b.mem_wdata;  assign m_wdata[2] = bus_c.mem_wdata;
  assign m_frd[0]   = bus_a.f_rdata;    assign m_frd[1]   = bus_b.f_rdata;    assign m_frd[2]   = bus_c.f_rdata;
  assign m_drd[0]   = bus_a.d_rdata;    assign m_drd[1]   = bus_b.d_rdata;    assign m_drd[2]   = bus_c.d_rdata;

  // Scoreboard: record each access's strobes, pop and compare on every done.
  initial begin
    int            scnt   [3];
    logic [AW-1:0] saddr  [3];
    logic          swe    [3];
    logic [DW-1:0] swdata [3];
    logic [DW-1:0] efrd   [3];
    logic [DW-1:0] edrd   [3];
    exp_t          e;
    bit            have_e;
    for (int i = 0; i < 3; i++) begin
      scnt[i] = 0; saddr[i] = '0; swe[i] = 1'b0; swdata[i] = '0; efrd[i] = '0; edrd[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          scnt[i] = 0; efrd[i] = '0; edrd[i] = '0;
        end else begin
          if (m_rd[i] || m_wr[i]) begin
            if (scnt[i] == 0) begin
              saddr[i] = m_addr[i]; swe[i] = m_wr[i]; swdata[i] = m_wdata[i];
            end
            scnt[i]++;
          end
          if (m_fdone[i] || m_ddone[i]) begin
            have_e = 1'b0;
            case (i)
              0: if (q_a.size() != 0) begin e = q_a.pop_front(); have_e = 1'b1; end
              1: if (q_b.size() != 0) begin e = q_b.pop_front(); have_e = 1'b1; end
              default: if (q_c.size() != 0) begin e = q_c.pop_front(); have_e = 1'b1; end
            endcase
            checks++;
            if (!have_e) begin
              errors++;
              $display("FAIL sb_unexpected_done dut%0d: got done f=%b d=%b, required no done", i, m_fdone[i], m_ddone[i]);
            end else begin
              checks++;
              if ((m_fdone[i] && m_ddone[i]) || (m_ddone[i] !== e.port) || m_rd[i] || m_wr[i]) begin
                errors++;
                $display("FAIL sb_port dut%0d: got f_done=%b d_done=%b rd=%b wr=%b, required port %0d alone with strobes 0",
                         i, m_fdone[i], m_ddone[i], m_rd[i], m_wr[i], e.port);
              end
              checks++;
              if (saddr[i] !== e.addr || swe[i] !== e.we) begin
                errors++;
                $display("FAIL sb_addr dut%0d: got addr=%03h we=%b, required addr=%03h we=%b", i, saddr[i], swe[i], e.addr, e.we);
              end
              checks++;
              if (scnt[i] != exp_wait(i)) begin
                errors++;
                $display("FAIL sb_strobe_len dut%0d: got %0d strobe cycles, required %0d", i, scnt[i], exp_wait(i));
              end
              if (e.we) begin
                checks++;
                if (swdata[i] !== e.wdata) begin
                  errors++;
                  $display("FAIL sb_wdata dut%0d: got %08h, required %08h", i, swdata[i], e.wdata);
                end
              end else if (e.port) begin
                edrd[i] = e.rdata;
              end else begin
                efrd[i] = e.rdata;
              end
              checks++;
              if (m_frd[i] !== efrd[i] || m_drd[i] !== edrd[i]) begin
                errors++;
                $display("FAIL sb_rdata dut%0d: got f_rdata=%08h d_rdata=%08h, required %08h %08h",
                         i, m_frd[i], m_drd[i], efrd[i], edrd[i]);
              end
              $display("dut%0d %s addr=%03h we=%0b wdata=%08h f_rdata=%08h d_rdata=%08h",
                       i, e.port ? "data " : "fetch", e.addr, e.we, e.wdata, m_frd[i], m_drd[i]);
            end
            scnt[i] = 0;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.busy, bus_a.mem_read, bus_a.mem_write, bus_a.f_done, bus_a.d_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/rd/wr/fd/dd=%b, required 00000",
               {bus_a.busy, bus_a.mem_read, bus_a.mem_write, bus_a.f_done, bus_a.d_done});
    end
    checks++;
    if (bus_a.f_rdata !== 32'h0 || bus_a.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %08h %08h, required 0 0", bus_a.f_rdata, bus_a.d_rdata);
    end
    checks++;
    if (bus_a.mem_addr !== 9'h0 || bus_a.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%03h wdata=%08h, required 0 0", bus_a.mem_addr, bus_a.mem_wdata);
    end
    checks++;
    if (bus_b.busy !== 1'b0 || bus_c.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_bc: got %b %b, required 0 0", bus_b.busy, bus_c.busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got busy=%b, required 0", bus_a.busy);
    end
  endtask

  task automatic test_fetch_read();
    int lat = 0;
    int rd_cycles = 0;
    bit seen = 0;
    bit d_seen = 0;
    @(posedge clk);
    #1;
    bus_a.f_addr = 9'h010;
    bus_a.f_req  = 1'b1;
    q_a.push_back(mk_exp(1'b0, 9'h010, 1'b0, 32'h0));
    while (!seen && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus_a.mem_read) begin
        rd_cycles++;
        checks++;
        if (bus_a.mem_addr !== 9'h010) begin
          errors++;
          $display("FAIL fetch_addr: got %03h, required 010", bus_a.mem_addr);
        end
      end
      if (bus_a.d_done) d_seen = 1;
      if (bus_a.f_done) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL fetch_timeout: got no f_done, required f_done"); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL fetch_latency: got %0d, required 3", lat); end
    checks++;
    if (rd_cycles != 2) begin errors++; $display("FAIL fetch_read_len: got %0d, required 2", rd_cycles); end
    checks++;
    if (bus_a.f_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL fetch_rdata: got %08h, required 12345678", bus_a.f_rdata);
    end
    checks++;
    if (d_seen) begin errors++; $display("FAIL fetch_no_ddone: got d_done=1, required 0"); end
    @(posedge clk);
    #1 bus_a.f_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.f_done !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.f_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL fetch_after: got f_done=%b busy=%b f_rdata=%08h, required 0 0 12345678",
               bus_a.f_done, bus_a.busy, bus_a.f_rdata);
    end
  endtask

  task automatic test_store();
    int lat = 0;
    int wr_cycles = 0;
    bit seen = 0;
    bit f_seen = 0;
    @(posedge clk);
    #1;
    bus_a.d_we    = 1'b1;
    bus_a.d_addr  = 9'h0AB;
    bus_a.d_wdata = 32'hDEAD_BEEF;
    bus_a.d_req   = 1'b1;
    q_a.push_back(mk_exp(1'b1, 9'h0AB, 1'b1, 32'hDEAD_BEEF));
    while (!seen && lat < 20) begin
      @(posedge clk); lat++;
      if (lat == 1) begin
        // Changes after the grant must not leak into the access.
        #1;
        bus_a.d_addr  = 9'h155;
        bus_a.d_wdata = 32'h0;
      end
      @(negedge clk);
      if (bus_a.mem_write) begin
        wr_cycles++;
        checks++;
        if (bus_a.mem_wdata !== 32'hDEAD_BEEF || bus_a.mem_addr !== 9'h0AB || bus_a.mem_read !== 1'b0) begin
          errors++;
          $display("FAIL store_bus: got addr=%03h wdata=%08h rd=%b, required 0ab deadbeef 0",
                   bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_read);
        end
      end
      if (bus_a.f_done) f_seen = 1;
      if (bus_a.d_done) seen = 1;
    end
    checks++;
    if (!seen || lat != 3) begin
      errors++; $display("FAIL store_done: got seen=%0d latency=%0d, required 1 3", seen, lat);
    end
    checks++;
    if (wr_cycles != 2) begin errors++; $display("FAIL store_write_len: got %0d, required 2", wr_cycles); end
    checks++;
    if (f_seen) begin errors++; $display("FAIL store_no_fdone: got f_done=1, required 0"); end
    checks++;
    if (bus_a.f_rdata !== 32'h1234_5678 || bus_a.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_rdata_kept: got %08h %08h, required 12345678 00000000", bus_a.f_rdata, bus_a.d_rdata);
    end
    @(posedge clk);
    #1;
    bus_a.d_req = 1'b0;
    bus_a.d_we  = 1'b0;
  endtask

  task automatic test_priority();
    int t = 0, td = 0, tf = 0;
    bit dd = 0, fd = 0, d_pend = 0, f_pend = 0, fdropped = 0;
    @(posedge clk);
    #1;
    bus_a.f_addr = 9'h020; bus_a.f_req = 1'b1;
    bus_a.d_we   = 1'b0;   bus_a.d_addr = 9'h0C0; bus_a.d_req = 1'b1;
    q_a.push_back(mk_exp(1'b1, 9'h0C0, 1'b0, 32'h0));
    q_a.push_back(mk_exp(1'b0, 9'h020, 1'b0, 32'h0));
    while (!fdropped && t < 40) begin
      @(posedge clk); t++;
      if (d_pend) begin #1 bus_a.d_req = 1'b0; d_pend = 0; end
      if (f_pend) begin #1 bus_a.f_req = 1'b0; f_pend = 0; fdropped = 1; end
      @(negedge clk);
      if (bus_a.d_done && !dd) begin dd = 1; td = t; d_pend = 1; end
      if (bus_a.f_done && !fd) begin fd = 1; tf = t; f_pend = 1; end
    end
    checks++;
    if (!dd || !fd || td != 3) begin
      errors++; $display("FAIL prio_done: got d=%0d f=%0d td=%0d, required 1 1 3", dd, fd, td);
    end
    checks++;
    if (tf - td != 4) begin errors++; $display("FAIL prio_spacing: got %0d, required 4", tf - td); end
    checks++;
    if (bus_a.d_rdata !== model(9'h0C0) || bus_a.f_rdata !== model(9'h020)) begin
      errors++;
      $display("FAIL prio_rdata: got %08h %08h, required %08h %08h",
               bus_a.d_rdata, bus_a.f_rdata, model(9'h0C0), model(9'h020));
    end
  endtask

  task automatic test_round_robin();
    int t = 0, n = 0, tprev = 0;
    logic [3:0] seq = 4'b0;
    bit pend = 0, dropped = 0, gap_bad = 0;
    @(posedge clk);
    #1;
    bus_b.f_addr = 9'h030; bus_b.f_req = 1'b1;
    bus_b.d_we   = 1'b0;   bus_b.d_addr = 9'h100; bus_b.d_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      q_b.push_back(mk_exp(1'b1, 9'h100, 1'b0, 32'h0));
      q_b.push_back(mk_exp(1'b0, 9'h030, 1'b0, 32'h0));
    end
    while (!dropped && t < 60) begin
      @(posedge clk); t++;
      if (pend) begin #1; bus_b.f_req = 1'b0; bus_b.d_req = 1'b0; dropped = 1; end
      @(negedge clk);
      if (bus_b.f_done || bus_b.d_done) begin
        seq = {seq[2:0], bus_b.d_done};
        if (n > 0 && t - tprev != 4) gap_bad = 1;
        tprev = t;
        n++;
        if (n == 4) pend = 1;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_count: got %0d, required 4", n); end
    checks++;
    if (seq !== 4'b1010) begin errors++; $display("FAIL rr_order: got %b (1=data), required 1010", seq); end
    checks++;
    if (gap_bad) begin errors++; $display("FAIL rr_spacing: got irregular done spacing, required 4"); end
  endtask

  task automatic test_req_drop();
    int lat = 0;
    int busy_cycles = 0;
    bit seen = 0;
    @(posedge clk);
    #1;
    bus_a.d_we = 1'b0; bus_a.d_addr = 9'h077; bus_a.d_req = 1'b1;
    q_a.push_back(mk_exp(1'b1, 9'h077, 1'b0, 32'h0));
    while (!seen && lat < 20) begin
      @(posedge clk); lat++;
      if (lat == 1) #1 bus_a.d_req = 1'b0;
      @(negedge clk);
      if (bus_a.d_done) seen = 1;
    end
    checks++;
    if (!seen || lat != 3) begin
      errors++; $display("FAIL drop_done: got seen=%0d latency=%0d, required 1 3", seen, lat);
    end
    checks++;
    if (bus_a.d_rdata !== model(9'h077)) begin
      errors++; $display("FAIL drop_rdata: got %08h, required %08h", bus_a.d_rdata, model(9'h077));
    end
    repeat (4) begin
      @(negedge clk);
      if (bus_a.busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 0) begin errors++; $display("FAIL drop_idle: got %0d busy cycles, required 0", busy_cycles); end
  endtask

  task automatic test_reset_mid_access();
    int lat = 0;
    bit seen = 0;
    bit bad = 0;
    @(posedge clk);
    #1;
    bus_a.f_addr = 9'h040; bus_a.f_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_a.mem_read !== 1'b1) begin
      errors++; $display("FAIL rstmid_started: got mem_read=%b, required 1", bus_a.mem_read);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus_a.f_req = 1'b0;
    #1;
    checks++;
    if (bus_a.mem_read !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.f_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_immediate: got rd=%b busy=%b f_done=%b, required 0 0 0",
               bus_a.mem_read, bus_a.busy, bus_a.f_done);
    end
    repeat (2) begin
      @(negedge clk);
      if (bus_a.f_done || bus_a.busy) bad = 1;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus_a.f_done || bus_a.d_done || bus_a.busy) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rstmid_abandon: got done/busy after reset, required none"); end
    @(posedge clk);
    #1;
    bus_a.f_addr = 9'h001; bus_a.f_req = 1'b1;
    q_a.push_back(mk_exp(1'b0, 9'h001, 1'b0, 32'h0));
    while (!seen && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus_a.f_done) seen = 1;
    end
    checks++;
    if (!seen || lat != 3 || bus_a.f_rdata !== model(9'h001)) begin
      errors++;
      $display("FAIL rstmid_recover: got seen=%0d latency=%0d f_rdata=%08h, required 1 3 %08h",
               seen, lat, bus_a.f_rdata, model(9'h001));
    end
    @(posedge clk);
    #1 bus_a.f_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t = 0, n = 0, tprev = 0, tfirst = 0;
    bit pend = 0, dropped = 0, gap_bad = 0;
    @(posedge clk);
    #1;
    bus_c.f_addr = 9'h005; bus_c.f_req = 1'b1;
    for (int k = 0; k < 3; k++) q_c.push_back(mk_exp(1'b0, 9'(5 + k), 1'b0, 32'h0));
    while (!dropped && t < 40) begin
      @(posedge clk); t++;
      if (pend) begin
        #1;
        if (n < 3) bus_c.f_addr = 9'(5 + n);
        else begin bus_c.f_req = 1'b0; dropped = 1; end
        pend = 0;
      end
      @(negedge clk);
      if (bus_c.f_done) begin
        checks++;
        if (bus_c.f_rdata !== model(9'(5 + n))) begin
          errors++;
          $display("FAIL b2b_rdata%0d: got %08h, required %08h", n, bus_c.f_rdata, model(9'(5 + n)));
        end
        if (n == 0) tfirst = t;
        else if (t - tprev != 3) gap_bad = 1;
        tprev = t;
        n++;
        pend = 1;
      end
    end
    checks++;
    if (n != 3 || tfirst != 2) begin
      errors++; $display("FAIL b2b_count: got n=%0d first=%0d, required 3 2", n, tfirst);
    end
    checks++;
    if (gap_bad) begin errors++; $display("FAIL b2b_spacing: got irregular done spacing, required 3"); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.f_req = 1'b0; bus_a.f_addr = '0; bus_a.d_req = 1'b0; bus_a.d_we = 1'b0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_b.f_req = 1'b0; bus_b.f_addr = '0; bus_b.d_req = 1'b0; bus_b.d_we = 1'b0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
    bus_c.f_req = 1'b0; bus_c.f_addr = '0; bus_c.d_req = 1'b0; bus_c.d_we = 1'b0; bus_c.d_addr = '0; bus_c.d_wdata = '0;
    test_reset();
    test_fetch_read();
    test_store();
    test_priority();
    test_round_robin();
    test_req_drop();
    test_reset_mid_access();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d %0d %0d pending, required 0 0 0", q_a.size(), q_b.size(), q_c.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
